// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns the EX/MEM load/store request into a
// req/ack bus transaction, steering store lanes and extending load data.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] MEM_ADDR_IN,
   input  logic [31:0] MEM_STORE_DATA,
   input  logic        MEM_MEM_READ,
   input  logic        MEM_MEM_WRITE,
   input  logic [2:0]  MEM_FUNC3,
   input  logic        BUS_ACK,
   input  logic [31:0] BUS_RDATA,
   output logic        BUS_REQ,
   output logic        BUS_WE,
   output logic [31:0] BUS_ADDR,
   output logic [31:0] BUS_WDATA,
   output logic [3:0]  BUS_BE,
   output logic [31:0] LOAD_DATA,
   output logic        STALL,
   output logic        MISALIGNED,
   output logic        BUS_ERR
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t            state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [1:0]        off_reg;
   logic [2:0]        func3_reg;

   logic        access;
   logic        is_write;
   logic        misaligned;
   logic [1:0]  off_in;
   logic [3:0]  be_steer;
   logic [31:0] wdata_steer;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_ext;

   // A simultaneous read+write request is served as a read.
   assign access   = MEM_MEM_READ | MEM_MEM_WRITE;
   assign is_write = MEM_MEM_WRITE & ~MEM_MEM_READ;
   assign off_in   = MEM_ADDR_IN[1:0];

   assign misaligned = ((MEM_FUNC3[1:0] == 2'b01) && off_in[0]) ||
                       ((MEM_FUNC3[1:0] == 2'b10) && (off_in != 2'b00));

   // STALL asserts in the request cycle itself so the pipeline never advances past it.
   assign STALL = (state_reg == ST_WAIT) ||
                  ((state_reg == ST_IDLE) && access && !misaligned);

   always_comb begin
      be_steer    = 4'b0000;
      wdata_steer = MEM_STORE_DATA;
      case (MEM_FUNC3[1:0])
         2'b00: begin
            be_steer    = 4'b0001 << off_in;
            wdata_steer = {4{MEM_STORE_DATA[7:0]}};
         end
         2'b01: begin
            be_steer    = 4'b0011 << off_in;
            wdata_steer = {2{MEM_STORE_DATA[15:0]}};
         end
         2'b10: begin
            be_steer    = 4'hF;
            wdata_steer = MEM_STORE_DATA;
         end
         default: begin
            be_steer    = 4'b0000;
            wdata_steer = MEM_STORE_DATA;
         end
      endcase
   end

   // Extraction uses the offset/funct3 latched at request time, not the live inputs.
   always_comb begin
      load_byte = BUS_RDATA[8*off_reg +: 8];
      load_half = BUS_RDATA[16*off_reg[1] +: 16];
      case (func3_reg)
         3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
         3'b100:  load_ext = {24'b0, load_byte};
         3'b001:  load_ext = {{16{load_half[15]}}, load_half};
         3'b101:  load_ext = {16'b0, load_half};
         3'b010:  load_ext = BUS_RDATA;
         default: load_ext = 32'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         off_reg    <= 2'b00;
         func3_reg  <= 3'b000;
         BUS_REQ    <= 1'b0;
         BUS_WE     <= 1'b0;
         BUS_ADDR   <= 32'b0;
         BUS_WDATA  <= 32'b0;
         BUS_BE     <= 4'b0000;
         LOAD_DATA  <= 32'b0;
         MISALIGNED <= 1'b0;
         BUS_ERR    <= 1'b0;
      end else begin
         MISALIGNED <= 1'b0;
         BUS_ERR    <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (access) begin
                  if (misaligned) begin
                     MISALIGNED <= 1'b1;
                     LOAD_DATA  <= 32'b0;
                  end else begin
                     BUS_ADDR  <= {MEM_ADDR_IN[31:2], 2'b00};
                     BUS_WE    <= is_write;
                     BUS_BE    <= is_write ? be_steer : 4'b0000;
                     BUS_WDATA <= is_write ? wdata_steer : 32'b0;
                     BUS_REQ   <= 1'b1;
                     cnt_reg   <= '0;
                     off_reg   <= off_in;
                     func3_reg <= MEM_FUNC3;
                     state_reg <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               cnt_reg <= cnt_reg + 1'b1;
               // ACK wins over timeout when both land on the last cycle.
               if (BUS_ACK) begin
                  if (!BUS_WE) LOAD_DATA <= load_ext;
                  BUS_REQ   <= 1'b0;
                  state_reg <= ST_DONE;
               end else if (cnt_reg == CNT_LAST) begin
                  BUS_REQ   <= 1'b0;
                  BUS_ERR   <= 1'b1;
                  LOAD_DATA <= 32'b0;
                  state_reg <= ST_DONE;
               end
            end
            ST_DONE: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, timeout and reset abort.
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] MEM_ADDR_IN;
   logic [31:0] MEM_STORE_DATA;
   logic        MEM_MEM_READ;
   logic        MEM_MEM_WRITE;
   logic [2:0]  MEM_FUNC3;
   logic        BUS_ACK;
   logic [31:0] BUS_RDATA;
   logic        BUS_REQ;
   logic        BUS_WE;
   logic [31:0] BUS_ADDR;
   logic [31:0] BUS_WDATA;
   logic [3:0]  BUS_BE;
   logic [31:0] LOAD_DATA;
   logic        STALL;
   logic        MISALIGNED;
   logic        BUS_ERR;

   int checks = 0;
   int errors = 0;

   // Bus values observed while BUS_REQ was high during the last transaction.
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;
   logic        cap_we;
   int          stall_cnt, req_cnt;
   logic        done_ok;

   mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
      .CLK(CLK), .RST(RST),
      .MEM_ADDR_IN(MEM_ADDR_IN), .MEM_STORE_DATA(MEM_STORE_DATA),
      .MEM_MEM_READ(MEM_MEM_READ), .MEM_MEM_WRITE(MEM_MEM_WRITE),
      .MEM_FUNC3(MEM_FUNC3), .BUS_ACK(BUS_ACK), .BUS_RDATA(BUS_RDATA),
      .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
      .BUS_WDATA(BUS_WDATA), .BUS_BE(BUS_BE), .LOAD_DATA(LOAD_DATA),
      .STALL(STALL), .MISALIGNED(MISALIGNED), .BUS_ERR(BUS_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-16s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      MEM_MEM_READ  = 1'b0;
      MEM_MEM_WRITE = 1'b0;
      BUS_ACK       = 1'b0;
   endtask

   // Present a request and serve it; ack_at = WAIT cycle (1-based) carrying ACK, 0 = never.
   // Returns in the DONE cycle with the request still presented.
   task automatic xact(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input int ack_at, input logic [31:0] rdata);
      MEM_MEM_READ   = rd;
      MEM_MEM_WRITE  = wr;
      MEM_FUNC3      = f3;
      MEM_ADDR_IN    = addr;
      MEM_STORE_DATA = data;
      BUS_ACK        = 1'b0;
      BUS_RDATA      = rdata;
      stall_cnt = 0;
      req_cnt   = 0;
      done_ok   = 1'b0;
      #1;
      for (int i = 0; i < 40; i++) begin
         if (STALL) stall_cnt++;
         if (BUS_REQ) begin
            req_cnt++;
            cap_addr  = BUS_ADDR;
            cap_wdata = BUS_WDATA;
            cap_be    = BUS_BE;
            cap_we    = BUS_WE;
         end
         if (i > 0 && !STALL) begin
            done_ok = 1'b1;
            break;
         end
         BUS_ACK = BUS_REQ && (req_cnt == ack_at);
         cyc();
      end
      BUS_ACK = 1'b0;
      chk("xact_done", {31'b0, done_ok}, 32'd1);
   endtask

   // Leave DONE and confirm the unit is back to a quiet IDLE.
   task automatic finish_xact(input string tag);
      idle_inputs();
      cyc();
      chk({tag, "_idle_req"}, {31'b0, BUS_REQ}, 32'd0);
      chk({tag, "_idle_err"}, {31'b0, BUS_ERR}, 32'd0);
   endtask

   initial begin
      RST = 1'b1;
      MEM_ADDR_IN = 32'b0;
      MEM_STORE_DATA = 32'b0;
      MEM_FUNC3 = 3'b000;
      BUS_RDATA = 32'b0;
      idle_inputs();
      cyc();
      cyc();
      chk("rst_req",   {31'b0, BUS_REQ}, 32'd0);
      chk("rst_stall", {31'b0, STALL}, 32'd0);
      chk("rst_load",  LOAD_DATA, 32'd0);
      chk("rst_be",    {28'b0, BUS_BE}, 32'd0);
      chk("rst_flags", {30'b0, MISALIGNED, BUS_ERR}, 32'd0);
      RST = 1'b0;
      cyc();

      // LW, ACK in 3rd WAIT cycle.
      xact(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
      chk("lw_stall", stall_cnt, 32'd4);
      chk("lw_req",   req_cnt, 32'd3);
      chk("lw_addr",  cap_addr, 32'h0000_0100);
      chk("lw_we_be", {27'b0, cap_we, cap_be}, 32'd0);
      chk("lw_data",  LOAD_DATA, 32'hDEAD_BEEF);
      finish_xact("lw");
      chk("lw_hold",  LOAD_DATA, 32'hDEAD_BEEF);

      // Byte/half loads, zero-wait memory.
      xact(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h8011_2233);
      chk("lb_stall", stall_cnt, 32'd2);
      chk("lb_addr",  cap_addr, 32'h0000_0100);
      chk("lb_data",  LOAD_DATA, 32'hFFFF_FF80);
      finish_xact("lb");
      xact(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 1, 32'h8011_2233);
      chk("lbu_data", LOAD_DATA, 32'h0000_0080);
      finish_xact("lbu");
      xact(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 2, 32'h8011_2233);
      chk("lhu_data", LOAD_DATA, 32'h0000_8011);
      finish_xact("lhu");
      xact(1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0, 1, 32'h0000_8001);
      chk("lh_data",  LOAD_DATA, 32'hFFFF_8001);
      finish_xact("lh");
      xact(1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 1, 32'h1234_5678);
      chk("lb1_data", LOAD_DATA, 32'h0000_0056);
      finish_xact("lb1");

      // Unsupported load funct3: bus access still happens, result zero.
      xact(1'b1, 1'b0, 3'b011, 32'h0000_0104, 32'h0, 1, 32'h5555_5555);
      chk("bad_req",  req_cnt, 32'd1);
      chk("bad_data", LOAD_DATA, 32'd0);
      finish_xact("bad");

      // Stores: lane steering, LOAD_DATA untouched.
      xact(1'b1, 1'b0, 3'b010, 32'h0000_0108, 32'h0, 1, 32'h0BAD_F00D);
      finish_xact("pre");
      xact(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 2, 32'hFFFF_FFFF);
      chk("sb_addr",  cap_addr, 32'h0000_0200);
      chk("sb_we",    {31'b0, cap_we}, 32'd1);
      chk("sb_be",    {28'b0, cap_be}, 32'h2);
      chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
      chk("sb_load",  LOAD_DATA, 32'h0BAD_F00D);
      finish_xact("sb");
      xact(1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'h1234_ABCD, 1, 32'h0);
      chk("sh_be",    {28'b0, cap_be}, 32'hC);
      chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
      finish_xact("sh");
      xact(1'b0, 1'b1, 3'b010, 32'h0000_040C, 32'hCAFE_F00D, 1, 32'h0);
      chk("sw_be",    {28'b0, cap_be}, 32'hF);
      chk("sw_wdata", cap_wdata, 32'hCAFE_F00D);
      chk("sw_addr",  cap_addr, 32'h0000_040C);
      finish_xact("sw");

      // Read and write together is a read.
      xact(1'b1, 1'b1, 3'b010, 32'h0000_0500, 32'h1111_1111, 1, 32'h2468_ACE0);
      chk("rw_we_be", {27'b0, cap_we, cap_be}, 32'd0);
      chk("rw_data",  LOAD_DATA, 32'h2468_ACE0);
      finish_xact("rw");

      // Misaligned LW: pulse, no request, no stall.
      MEM_MEM_READ = 1'b1;
      MEM_FUNC3    = 3'b010;
      MEM_ADDR_IN  = 32'h0000_0102;
      #1;
      chk("mis_stall0", {31'b0, STALL}, 32'd0);
      cyc();
      chk("mis_pulse", {31'b0, MISALIGNED}, 32'd1);
      chk("mis_req",   {31'b0, BUS_REQ}, 32'd0);
      chk("mis_load",  LOAD_DATA, 32'd0);
      idle_inputs();
      cyc();
      chk("mis_clear", {31'b0, MISALIGNED}, 32'd0);
      chk("mis_req2",  {31'b0, BUS_REQ}, 32'd0);

      // Misaligned SH.
      MEM_MEM_WRITE = 1'b1;
      MEM_FUNC3     = 3'b001;
      MEM_ADDR_IN   = 32'h0000_0101;
      #1;
      chk("mish_stall", {31'b0, STALL}, 32'd0);
      cyc();
      chk("mish_pulse", {31'b0, MISALIGNED}, 32'd1);
      chk("mish_req",   {31'b0, BUS_REQ}, 32'd0);
      idle_inputs();
      cyc();

      // Timeout: no ACK at all.
      xact(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1, 32'h7777_7777);
      finish_xact("pre2");
      xact(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 0, 32'h0);
      chk("to_req",   req_cnt, 32'd16);
      chk("to_stall", stall_cnt, 32'd17);
      chk("to_err",   {31'b0, BUS_ERR}, 32'd1);
      chk("to_load",  LOAD_DATA, 32'd0);
      finish_xact("to");
      chk("to_stall2", {31'b0, STALL}, 32'd0);

      // ACK on the last permitted cycle is success.
      xact(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0, 16, 32'h1357_9BDF);
      chk("late_req",  req_cnt, 32'd16);
      chk("late_err",  {31'b0, BUS_ERR}, 32'd0);
      chk("late_data", LOAD_DATA, 32'h1357_9BDF);
      finish_xact("late");

      // Reset during the 2nd WAIT cycle aborts quietly.
      MEM_MEM_READ = 1'b1;
      MEM_FUNC3    = 3'b010;
      MEM_ADDR_IN  = 32'h0000_0800;
      cyc();
      chk("ab_req1", {31'b0, BUS_REQ}, 32'd1);
      cyc();
      chk("ab_req2", {31'b0, BUS_REQ}, 32'd1);
      RST = 1'b1;
      idle_inputs();
      cyc();
      chk("ab_req",   {31'b0, BUS_REQ}, 32'd0);
      chk("ab_stall", {31'b0, STALL}, 32'd0);
      chk("ab_err",   {31'b0, BUS_ERR}, 32'd0);
      RST = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("ab_quiet", {30'b0, BUS_ERR, BUS_REQ}, 32'd0);
      end

      // Normal operation resumes after the abort.
      xact(1'b1, 1'b0, 3'b010, 32'h0000_0900, 32'h0, 1, 32'hFACE_0001);
      chk("post_data", LOAD_DATA, 32'hFACE_0001);
      finish_xact("post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
